// File: rtl/serial_adder_seg.sv
// rtl/serial_adder_seg.sv - bit-serial add/sub with registered result and scanned hex 7-seg display
// Optional build macro SERIAL_ADDER_SIGNED_EN selects two's-complement result/overflow semantics.
module serial_adder_seg #(
    parameter int WIDTH       = 4,
    parameter int SCAN_CYCLES = 4,
    localparam int NUM_NIB    = (WIDTH + 4) / 4,
    localparam int NDIG       = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mode,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             overflow,
    output logic [7:0]       SEG,
    output logic [NDIG-1:0]  seg_digit
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             start_q;
    logic             start_accept;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [IW-1:0]    bit_idx;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;
    logic             msb_flag;
    logic             ovf_flag;
`ifndef SERIAL_ADDER_SIGNED_EN
    logic             sub_q;
`endif
    logic [CW-1:0]    scan_cnt;
    logic [4*NUM_NIB-1:0] res_pad;
    logic [3:0]       nibble;
    logic [6:0]       seg7;

    assign start_accept = start && !start_q && (state == S_IDLE);
    assign last_bit     = (bit_idx == IW'(WIDTH - 1));

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_accept) state_nxt = S_CALC;
            S_CALC:  if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_CALC);
        done = (state == S_DONE);
    end

    // One full-adder slice; the sum bit shifts into the top of a_sh as its LSB shifts out.
    assign fa_sum  = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_cout = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    always_comb begin
`ifdef SERIAL_ADDER_SIGNED_EN
        ovf_flag = carry ^ fa_cout;
        msb_flag = a_sh[0] ^ b_sh[0] ^ fa_cout;
`else
        msb_flag = fa_cout ^ sub_q;
        ovf_flag = fa_cout ^ sub_q;
`endif
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            start_q  <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            bit_idx  <= '0;
`ifndef SERIAL_ADDER_SIGNED_EN
            sub_q    <= 1'b0;
`endif
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            start_q <= start;
            if (start_accept) begin
                a_sh    <= op_a;
                b_sh    <= mode ? ~op_b : op_b;
                carry   <= mode;
                bit_idx <= '0;
`ifndef SERIAL_ADDER_SIGNED_EN
                sub_q   <= mode;
`endif
            end else if (state == S_CALC) begin
                a_sh    <= {fa_sum, a_sh[WIDTH-1:1]};
                b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                carry   <= fa_cout;
                bit_idx <= bit_idx + 1'b1;
                if (last_bit) begin
                    result   <= {msb_flag, fa_sum, a_sh[WIDTH-1:1]};
                    overflow <= ovf_flag;
                end
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            scan_cnt  <= '0;
            seg_digit <= '0;
        end else if (scan_cnt == CW'(SCAN_CYCLES - 1)) begin
            scan_cnt  <= '0;
            seg_digit <= (seg_digit == NDIG'(NUM_NIB - 1)) ? '0 : seg_digit + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Result is zero-padded up to a whole number of nibbles before selection.
    always_comb begin
        res_pad          = '0;
        res_pad[WIDTH:0] = result;
        nibble           = 4'h0;
        for (int i = 0; i < NUM_NIB; i++) begin
            if (seg_digit == NDIG'(i)) nibble = res_pad[4*i +: 4];
        end
    end

    always_comb begin
        seg7 = 7'h3F;
        case (nibble)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            4'hF: seg7 = 7'h71;
            default: seg7 = 7'h3F;
        endcase
        SEG = {overflow, seg7};
    end

endmodule

// File: tb/tb_serial_adder_seg.sv
// tb/tb_serial_adder_seg.sv - randomized and directed self-checking bench for serial_adder_seg
// Honours SERIAL_ADDER_SIGNED_EN in its reference model the same way the design does.
module tb_serial_adder_seg;

    localparam int WIDTH   = 4;
    localparam int SCAN    = 4;
    localparam int NUM_NIB = 2;

    logic             clk_2 = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mode;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;
    logic             overflow;
    logic [7:0]       SEG;
    logic [0:0]       seg_digit;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    logic [4:0] exp_res = '0;
    logic       exp_ovf = 1'b0;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    serial_adder_seg #(.WIDTH(WIDTH), .SCAN_CYCLES(SCAN)) dut (
        .clk_2(clk_2), .reset(reset), .op_a(op_a), .op_b(op_b), .mode(mode),
        .start(start), .busy(busy), .done(done), .result(result),
        .overflow(overflow), .SEG(SEG), .seg_digit(seg_digit)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        if (obs !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Tracks cycles since reset so the scan position is predicted independently.
    task automatic tick;
        @(posedge clk_2);
        if (reset) cyc = 0;
        else cyc++;
        #1;
    endtask

    function automatic void model(input logic [3:0] a, input logic [3:0] b, input logic m,
                                  output logic [4:0] res, output logic ovf);
        int t;
`ifdef SERIAL_ADDER_SIGNED_EN
        int sa;
        int sb;
        sa  = $signed(a);
        sb  = $signed(b);
        t   = m ? sa - sb : sa + sb;
        res = t[4:0];
        ovf = (t > 7) || (t < -8);
`else
        int ua;
        int ub;
        ua  = a;
        ub  = b;
        t   = m ? ua - ub : ua + ub;
        res = {m ? (ua < ub) : t[4], t[3:0]};
        ovf = res[4];
`endif
    endfunction

    task automatic check_display;
        int d;
        logic [4:0] sh;
        d  = (cyc / SCAN) % NUM_NIB;
        sh = exp_res >> (4 * d);
        chk("seg_digit", seg_digit, d);
        chk("seg", SEG, {exp_ovf, seg_tbl[sh[3:0]]});
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic m);
        int n;
        int busy_n;
        op_a  = a;
        op_b  = b;
        mode  = m;
        start = 1'b1;
        tick;
        chk("busy_after_start", busy, 1);
        n      = 0;
        busy_n = 0;
        while (!done && n < 20) begin
            if (busy) busy_n++;
            chk("result_hold", result, exp_res);
            op_a = 4'($urandom);
            op_b = 4'($urandom);
            mode = 1'($urandom);
            tick;
            n++;
        end
        chk("latency", n, WIDTH);
        chk("busy_cycles", busy_n, WIDTH);
        model(a, b, m, exp_res, exp_ovf);
        chk("result", result, exp_res);
        chk("overflow", overflow, exp_ovf);
        chk("busy_in_done", busy, 0);
        start = 1'b0;
        tick;
        chk("done_one_cycle", done, 0);
        check_display;
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        mode  = 1'b0;
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_digit", seg_digit, 0);
        chk("rst_seg", SEG, 8'h3F);
        reset = 1'b0;
        tick;

        // Directed vectors, then a sweep of the display across both digits.
        run_op(4'd5, 4'd3, 1'b0);
        run_op(4'hF, 4'h1, 1'b0);
        for (int i = 0; i < 2 * SCAN * NUM_NIB; i++) begin
            tick;
            check_display;
        end
        run_op(4'd2, 4'd5, 1'b1);
        run_op(4'd7, 4'd1, 1'b0);
        run_op(4'h8, 4'hF, 1'b0);
        run_op(4'd3, 4'd5, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom), 4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) tick;
            check_display;
        end

        // Held start gives exactly one operation.
        op_a  = 4'd6;
        op_b  = 4'd9;
        mode  = 1'b0;
        start = 1'b1;
        cnt   = 0;
        repeat (20) begin
            tick;
            if (done) cnt++;
        end
        model(4'd6, 4'd9, 1'b0, exp_res, exp_ovf);
        chk("hold_one_done", cnt, 1);
        chk("hold_result", result, exp_res);
        start = 1'b0;
        tick;

        // A new start edge during CALC is ignored.
        op_a  = 4'd9;
        op_b  = 4'd4;
        mode  = 1'b1;
        start = 1'b1;
        tick;
        tick;
        start = 1'b0;
        tick;
        op_a  = 4'd1;
        op_b  = 4'd1;
        mode  = 1'b0;
        start = 1'b1;
        cnt   = 0;
        repeat (12) begin
            tick;
            if (done) cnt++;
        end
        model(4'd9, 4'd4, 1'b1, exp_res, exp_ovf);
        chk("toggle_one_done", cnt, 1);
        chk("toggle_result", result, exp_res);
        chk("toggle_ovf", overflow, exp_ovf);
        start = 1'b0;
        tick;

        // Reset on the second CALC cycle aborts the operation.
        op_a  = 4'hE;
        op_b  = 4'h7;
        mode  = 1'b0;
        start = 1'b1;
        tick;
        tick;
        reset = 1'b1;
        tick;
        exp_res = '0;
        exp_ovf = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_seg", SEG, 8'h3F);
        reset = 1'b0;
        start = 1'b0;
        cnt   = 0;
        repeat (8) begin
            tick;
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        chk("abort_result_kept", result, 0);

        // Reset together with a start edge stays idle.
        reset = 1'b1;
        start = 1'b1;
        tick;
        chk("rst_start_busy", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        tick;
        chk("rst_start_idle", busy, 0);
        run_op(4'd4, 4'd4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
